// File: rtl/lcd_ctrl_pkg.sv
// lcd_ctrl_pkg -- shared definitions for the parametrised LCD controller.
//   * 4-bit host command codes
//   * controller state encoding
//   * window-slot indices (TL/TR/BL/BR) used by the top and the window ALU
package lcd_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE    = 4'd0;
    localparam logic [3:0] CMD_UP       = 4'd1;
    localparam logic [3:0] CMD_DOWN     = 4'd2;
    localparam logic [3:0] CMD_LEFT     = 4'd3;
    localparam logic [3:0] CMD_RIGHT    = 4'd4;
    localparam logic [3:0] CMD_MAX      = 4'd5;
    localparam logic [3:0] CMD_MIN      = 4'd6;
    localparam logic [3:0] CMD_AVG      = 4'd7;
    localparam logic [3:0] CMD_ROT_CCW  = 4'd8;
    localparam logic [3:0] CMD_ROT_CW   = 4'd9;
    localparam logic [3:0] CMD_MIRROR_X = 4'd10;
    localparam logic [3:0] CMD_MIRROR_Y = 4'd11;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int SLOT_TL = 0;
    localparam int SLOT_TR = 1;
    localparam int SLOT_BL = 2;
    localparam int SLOT_BR = 3;

endpackage

// File: rtl/lcd_win_alu.sv
// lcd_win_alu -- combinational 2x2 window operator.
// Ports:
//   cmd_i               command code (only pixel-changing codes act)
//   tl_i/tr_i/bl_i/br_i current window pixels
//   tl_o/tr_o/bl_o/br_o new window pixels (equal to inputs for other codes)
// Optional: LCD_CTRL_ROTATE_EN enables the two rotation commands; without it
// they fall through to the pass-through default.
module lcd_win_alu
    import lcd_ctrl_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic [3:0]       cmd_i,
    input  logic [PIX_W-1:0] tl_i,
    input  logic [PIX_W-1:0] tr_i,
    input  logic [PIX_W-1:0] bl_i,
    input  logic [PIX_W-1:0] br_i,
    output logic [PIX_W-1:0] tl_o,
    output logic [PIX_W-1:0] tr_o,
    output logic [PIX_W-1:0] bl_o,
    output logic [PIX_W-1:0] br_o
);

    logic [PIX_W-1:0] mx_t, mx_b, mx, mn_t, mn_b, mn;
    logic [PIX_W+1:0] sum;

    always_comb begin
        mx_t = (tl_i > tr_i) ? tl_i : tr_i;
        mx_b = (bl_i > br_i) ? bl_i : br_i;
        mx   = (mx_t > mx_b) ? mx_t : mx_b;
        mn_t = (tl_i < tr_i) ? tl_i : tr_i;
        mn_b = (bl_i < br_i) ? bl_i : br_i;
        mn   = (mn_t < mn_b) ? mn_t : mn_b;
        // two guard bits make the four-way sum overflow-free
        sum  = {2'b00, tl_i} + {2'b00, tr_i} + {2'b00, bl_i} + {2'b00, br_i};
    end

    always_comb begin
        tl_o = tl_i;
        tr_o = tr_i;
        bl_o = bl_i;
        br_o = br_i;
        case (cmd_i)
            CMD_MAX: begin
                tl_o = mx; tr_o = mx; bl_o = mx; br_o = mx;
            end
            CMD_MIN: begin
                tl_o = mn; tr_o = mn; bl_o = mn; br_o = mn;
            end
            CMD_AVG: begin
                tl_o = sum[PIX_W+1:2]; tr_o = sum[PIX_W+1:2];
                bl_o = sum[PIX_W+1:2]; br_o = sum[PIX_W+1:2];
            end
`ifdef LCD_CTRL_ROTATE_EN
            CMD_ROT_CCW: begin
                tl_o = tr_i; tr_o = br_i; br_o = bl_i; bl_o = tl_i;
            end
            CMD_ROT_CW: begin
                tl_o = bl_i; bl_o = br_i; br_o = tr_i; tr_o = tl_i;
            end
`endif
            CMD_MIRROR_X: begin
                tl_o = bl_i; bl_o = tl_i; tr_o = br_i; br_o = tr_i;
            end
            CMD_MIRROR_Y: begin
                tl_o = tr_i; tr_o = tl_i; bl_o = br_i; br_o = bl_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param -- parametrised LCD image controller.
// Loads IMG_W x IMG_H pixels from IROM, applies host commands to a 2x2
// window around a movable point, and streams the buffer to IRB on cmd 0.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cmd, cmd_valid      host command, accepted when busy=0
//   IROM_Q/IROM_EN/IROM_A   image source (registered read, EN active low)
//   IRB_RW/IRB_D/IRB_A      frame RAM write port (RW=0 writes)
//   busy, done          handshake: busy blocks commands, done pulses after write
// Optional: define LCD_CTRL_ROTATE_EN to enable rotate commands 8/9.
module lcd_ctrl_param
    import lcd_ctrl_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic              cmd_valid,
    input  logic [PIX_W-1:0]  IROM_Q,
    output logic              IROM_EN,
    output logic [ADDR_W-1:0] IROM_A,
    output logic              IRB_RW,
    output logic [PIX_W-1:0]  IRB_D,
    output logic [ADDR_W-1:0] IRB_A,
    output logic              busy,
    output logic              done
);

    localparam int N  = IMG_W * IMG_H;
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    state_e            state_q, state_d;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;
    logic [ADDR_W:0]   ld_cnt_q;
    logic              irom_en_q, cap_vld_q;
    logic [ADDR_W-1:0] irom_a_q, cap_a_q, wr_cnt_q;
    logic [3:0]        cmd_q;
    logic [PIX_W-1:0]  mem_q [N];

    logic [XW-1:0]     xm1;
    logic [YW-1:0]     ym1;
    logic [ADDR_W-1:0] win_a [4];
    logic [PIX_W-1:0]  res   [4];

    // Power-of-two geometry: address is simply {y, x}.
    always_comb begin
        xm1            = x_q - XW'(1);
        ym1            = y_q - YW'(1);
        win_a[SLOT_TL] = {ym1, xm1};
        win_a[SLOT_TR] = {ym1, x_q};
        win_a[SLOT_BL] = {y_q, xm1};
        win_a[SLOT_BR] = {y_q, x_q};
    end

    lcd_win_alu #(.PIX_W(PIX_W)) u_alu (
        .cmd_i (cmd_q),
        .tl_i  (mem_q[win_a[SLOT_TL]]),
        .tr_i  (mem_q[win_a[SLOT_TR]]),
        .bl_i  (mem_q[win_a[SLOT_BL]]),
        .br_i  (mem_q[win_a[SLOT_BR]]),
        .tl_o  (res[SLOT_TL]),
        .tr_o  (res[SLOT_TR]),
        .bl_o  (res[SLOT_BL]),
        .br_o  (res[SLOT_BR])
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_LOAD;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // leave LOAD once the last pixel has been captured
            ST_LOAD:  if (cap_vld_q && cap_a_q == ADDR_W'(N-1)) state_d = ST_IDLE;
            ST_IDLE:  if (cmd_valid) state_d = (cmd == CMD_WRITE) ? ST_WRITE : ST_EXEC;
            ST_EXEC:  state_d = ST_IDLE;
            ST_WRITE: if (wr_cnt_q == ADDR_W'(N-1)) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_cnt_q  <= '0;
            irom_en_q <= 1'b1;
            irom_a_q  <= '0;
            cap_vld_q <= 1'b0;
            cap_a_q   <= '0;
            wr_cnt_q  <= '0;
            cmd_q     <= '0;
            x_q       <= XW'(IMG_W/2);
            y_q       <= YW'(IMG_H/2);
        end else begin
            // IROM data arrives one cycle after the address: track the
            // address that the current IROM_Q belongs to.
            cap_vld_q <= ~irom_en_q;
            cap_a_q   <= irom_a_q;
            if (state_q == ST_LOAD) begin
                if (ld_cnt_q < (ADDR_W+1)'(N)) begin
                    irom_en_q <= 1'b0;
                    irom_a_q  <= ld_cnt_q[ADDR_W-1:0];
                    ld_cnt_q  <= ld_cnt_q + 1'b1;
                end else begin
                    irom_en_q <= 1'b1;
                end
            end
            if (state_q == ST_IDLE && cmd_valid) cmd_q <= cmd;
            if (state_q == ST_WRITE)
                wr_cnt_q <= (wr_cnt_q == ADDR_W'(N-1)) ? '0 : wr_cnt_q + 1'b1;
            if (state_q == ST_EXEC) begin
                case (cmd_q)
                    CMD_UP:    if (y_q > YW'(1))       y_q <= ym1;
                    CMD_DOWN:  if (y_q < YW'(IMG_H-1)) y_q <= y_q + YW'(1);
                    CMD_LEFT:  if (x_q > XW'(1))       x_q <= xm1;
                    CMD_RIGHT: if (x_q < XW'(IMG_W-1)) x_q <= x_q + XW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Image buffer: no reset, written by load capture or by EXEC write-back.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_LOAD && cap_vld_q) begin
                mem_q[cap_a_q] <= IROM_Q;
            end else if (state_q == ST_EXEC) begin
                for (int s = 0; s < 4; s++) mem_q[win_a[s]] <= res[s];
            end
        end
    end

    assign IROM_EN = irom_en_q;
    assign IROM_A  = irom_a_q;
    assign IRB_RW  = (state_q != ST_WRITE);
    assign IRB_A   = wr_cnt_q;
    assign IRB_D   = (state_q == ST_WRITE) ? mem_q[wr_cnt_q] : '0;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: doc/lcd_ctrl_param.md
Name: lcd_ctrl_param

Overview:
Parametrised next-generation LCD image controller.
- Loads an IMG_W x IMG_H image of PIX_W-bit pixels from IROM into an internal buffer.
- Executes host commands on a 2x2 window around a movable operation point: shift, max, min, average, mirror, rotate.
- Streams the buffer to the IRB frame RAM on a write command.
- Unlike the previous generation, it returns to IDLE after a write, so it can accept further commands and write-backs.

Parameters:
- IMG_W, 8, image width in pixels (power of 2, >=2)
- IMG_H, 8, image height in pixels (power of 2, >=2)
- PIX_W, 8, pixel width in bits
- ADDR_W, 6, buffer/IROM/IRB address width; must equal clog2(IMG_W*IMG_H)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cmd  in  4  command code
- cmd_valid  in  1  cmd qualifier
- IROM_Q  in  PIX_W  IROM read data, valid the cycle after IROM_A is driven
- IROM_EN  out  1  IROM enable, active low
- IROM_A  out  ADDR_W  IROM address
- IRB_RW  out  1  IRB access: 1 = read/idle, 0 = write
- IRB_D  out  PIX_W  IRB write data
- IRB_A  out  ADDR_W  IRB address
- busy  out  1  controller cannot accept a command
- done  out  1  one-cycle pulse marking the end of a write-back

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Asserting reset at any time, including mid-load or mid-write, aborts the operation and restarts LOAD from address 0.
- Reset values: IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, busy=1, done=0.
- Operation point after load: x=IMG_W/2, y=IMG_H/2.
- Window pixels, addressed as y*IMG_W+x:
  - TL=(x-1,y-1), TR=(x,y-1)
  - BL=(x-1,y), BR=(x,y)
- States: LOAD -> IDLE -> EXEC | WRITE; WRITE -> DONE -> IDLE.
- LOAD:
  - At load cycle k (k=0..N-1, N=IMG_W*IMG_H): IROM_EN=0, IROM_A=k.
  - buf[k] captures IROM_Q at cycle k+1.
  - After the last capture: IROM_EN=1, busy=0, state=IDLE. Total is N+1 cycles after reset is released.
- IDLE: busy=0. A command is accepted when cmd_valid=1 and busy=0. busy=1 from the next cycle. cmd_valid while busy=1 is ignored; no queueing.
- EXEC: exactly one cycle, then IDLE. Command actions:
  - 1 shift up: y-1, clamped at 1
  - 2 shift down: y+1, clamped at IMG_H-1
  - 3 shift left: x-1, clamped at 1
  - 4 shift right: x+1, clamped at IMG_W-1
  - 5 max: all four pixels = max of the window
  - 6 min: all four pixels = min of the window
  - 7 average: all four pixels = floor(sum/4). sum is PIX_W+2 bits, so no overflow.
  - 8 rotate CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL
  - 9 rotate CW: TL<=BL, BL<=BR, BR<=TR, TR<=TL
  - 10 mirror X: swap TL<->BL and TR<->BR
  - 11 mirror Y: swap TL<->TR and BL<->BR
  - 12-15: no-op; busy is still held high for one cycle.
  - A shift at a clamp boundary is a no-op.
- WRITE (cmd 0): N cycles.
  - At write cycle j: IRB_RW=0, IRB_A=j, IRB_D=buf[j], all on the same cycle.
  - The operation point is unchanged by a write.
- DONE: one cycle with IRB_RW=1, done=1, busy=1. Next cycle is IDLE with busy=0.

Optional Feature:
- Macro: LCD_CTRL_ROTATE_EN.
- Defined: cmds 8 and 9 perform the rotations above.
- Undefined: rotate logic is absent and cmds 8 and 9 behave as no-ops (busy high for 1 cycle, buffer unchanged).

Decomposition:
- Package lcd_ctrl_pkg:
  - 4-bit command code constants (CMD_WRITE..CMD_MIRROR_Y)
  - state encoding
  - window-slot index constants
- Sub-module lcd_win_alu: combinational. Inputs are the four window pixels and cmd; outputs are the four result pixels (max/min/avg/rotate/mirror). The top level owns the buffer, FSM and cursor.

Test Plan (all with IROM pixel[i]=i, default parameters):
- Load then cmd 0 -> 64 write cycles with IRB_A 0..63 and IRB_D=IRB_A; done pulses exactly one cycle; busy=0 on the following cycle.
- Cmd 7 at (4,4), window 27/28/35/36 -> write-back shows 31 at addresses 27, 28, 35, 36.
- Cmd 5 then cmd 0 -> addresses 27/28/35/36 = 36. After a fresh reset, cmd 6 -> 27.
- Five cmd 1 -> y clamps at 1. Then cmd 10 -> buf[3] and buf[11] swapped, buf[4] and buf[12] swapped.
- Cmd 9 with LCD_CTRL_ROTATE_EN -> buf[27]=35, buf[28]=27, buf[36]=28, buf[35]=36. Without the macro -> buffer unchanged.
- cmd_valid held high during busy, plus reset asserted mid-write at j=20 -> extra commands ignored; IROM_A restarts at 0, IRB_RW=1, done never asserts.
